hilo_mdu: RTL and testbench
===========================

# hilo_mdu

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. It executes MULT, MULTU, DIV and DIVU over a fixed number of cycles, and services MTHI/MTLO writes. Its `hi` and `lo` outputs feed the HI and LO inputs of the 5-way writeback result mux. `busy` drives the pipeline stall logic for MFHI/MFLO and for any new multiply/divide.

## Interface
- `WIDTH`, default 32: operand and HI/LO width.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: launch the operation in `op`. Sampled only when idle.
- `op`  in  2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH: rs operand, i.e. multiplicand or dividend.
- `b`  in  WIDTH: rt operand, i.e. multiplier or divisor.
- `mthi`  in  1: write `wdata` into HI.
- `mtlo`  in  1: write `wdata` into LO.
- `wdata`  in  WIDTH: MTHI/MTLO data.
- `busy`  out  1: an operation is in flight.
- `done`  out  1: one-cycle pulse when new HI/LO become visible.
- `hi`  out  WIDTH: HI register.
- `lo`  out  WIDTH: LO register.

## Operation
- **States:**
  - IDLE → PREP when `start`=1.
  - PREP → ITER after 1 cycle.
  - ITER → FIX after exactly WIDTH cycles, counted by an internal counter.
  - FIX → IDLE after 1 cycle.
- **Reset:** `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- **Operand capture:** `op`, `a` and `b` are registered on the accepting edge. Later input changes have no effect.
- **PREP:** computes operand magnitudes for the signed ops and the result signs. For unsigned ops, magnitudes are the raw operands.
- **ITER, multiply:** radix-2 shift-add, one partial-product bit per cycle, 2·WIDTH-bit accumulator.
- **ITER, divide:** restoring division, one quotient bit per cycle.
- **FIX:** applies sign correction and writes both `hi` and `lo` on the same edge.
  - Multiply: `hi` = product[2W-1:W], `lo` = product[W-1:0].
  - Divide: `lo` = quotient, `hi` = remainder.
- **Signed divide rules:**
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Overflow case -2^(W-1) / -1 gives `lo` = 0x80000000 and `hi` = 0. No trap.
- **Divide by zero** (DIV or DIVU, `b`=0): `lo` = all ones, `hi` = `a`. Latency is unchanged.
- **HI/LO stability:** `hi` and `lo` hold their previous values for the entire operation. Intermediate results are never visible.
- **Busy rules:**
  - `start` while busy is ignored; no queuing.
  - `mthi`/`mtlo` while busy are ignored.
- **MTHI/MTLO in IDLE:** applied on the next edge. Both may be asserted in the same cycle.
  - If `start` is also asserted, the move is applied and the operation is launched.
  - The operation's result later overwrites both registers.
- **Reset mid-operation:** aborts the operation. No `done` pulse, and HI/LO clear to 0.

## Timing
- Cycle 0: `start`=1 in IDLE.
- Cycles 1 to WIDTH+2: `busy`=1. That is cycles 1–34 for W=32: PREP in cycle 1, ITER in cycles 2–33, FIX in cycle 34.
- Cycle WIDTH+3 (cycle 35): new `hi`/`lo` visible, `done`=1 for this cycle only, `busy`=0.
- A new `start` is accepted in cycle 35, giving a back-to-back throughput of one operation per 35 cycles.
- `busy` and `done` are registered, derived from state with no combinational path from the inputs.
- MTHI/MTLO latency is 1 cycle. `done` is not asserted for moves.

## Test plan
- **MULTU:** `a`=0xFFFFFFFF, `b`=0xFFFFFFFF, `start` at cycle 0 → `busy` high cycles 1–34; cycle 35: `hi`=0xFFFFFFFE, `lo`=0x00000001, `done`=1 for one cycle.
- **MULT:** `a`=0xFFFFFFFD (-3), `b`=5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Also MULT 0x80000000×0x80000000 → `hi`=0x40000000, `lo`=0.
- **DIV:** `a`=0xFFFFFFF9 (-7), `b`=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7/2 → `lo`=3, `hi`=1. DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Divide by zero:** DIVU `a`=100, `b`=0 → cycle 35: `lo`=0xFFFFFFFF, `hi`=100.
- **Busy filtering:** `mthi` with `wdata`=0x1234 and a second `start` during cycle 10 of a MULTU 6×7 are both ignored. Cycle 35: `hi`=0, `lo`=42, and only one `done` pulse occurs. MTHI 0xABCD in IDLE → `hi`=0xABCD the next cycle.
- **Reset mid-operation:** `reset` in cycle 10 of a DIV → next cycle `busy`=0, `hi`=`lo`=0, and no `done` at cycle 35. A fresh `start` afterwards completes normally in 35 cycles.

Source files
------------

// File: rtl/hilo_mdu.sv
// ---------------------------------------------------------------------------
// hilo_mdu
//   Iterative multiply/divide unit owning the architectural HI/LO registers.
//   Executes MULT, MULTU, DIV and DIVU in WIDTH+3 cycles (PREP, WIDTH x ITER,
//   FIX), and services MTHI/MTLO moves while idle.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : synchronous, active-high
//   start      : launch op (only honoured in IDLE)
//   op         : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b       : rs / rt operands (multiplicand/dividend, multiplier/divisor)
//   mthi, mtlo : write wdata into HI / LO (only honoured in IDLE)
//   wdata      : move data
//   busy       : operation in flight (registered)
//   done       : one-cycle pulse when new HI/LO become visible (registered)
//   hi, lo     : HI / LO registers
//   fsm_state  : current controller state (00 IDLE, 01 PREP, 10 ITER, 11 FIX)
//
// Handshake: start/mthi/mtlo are single-cycle requests sampled on the rising
// edge only while busy is low; anything presented while busy is high is
// dropped, never queued. done marks the first cycle the results are visible.
// ---------------------------------------------------------------------------
module hilo_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       fsm_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_ITER = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]      count;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               neg_q, neg_r;
  logic [2*WIDTH-1:0] acc;

  logic               is_div, is_signed;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh, rem_sub;
  logic               rem_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rmd_fix;

  assign fsm_state = state;

  // ------------------------------------------------------------------
  // Controller
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_PREP;
      S_PREP: state_nxt = S_ITER;
      S_ITER: if (count == CW'(WIDTH - 1)) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // busy/done are flops so the stall logic sees no path from start.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt != S_IDLE);
      done <= (state == S_FIX);
    end
  end

  // ------------------------------------------------------------------
  // Datapath helpers
  // ------------------------------------------------------------------
  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];

  // Magnitude of the most negative value wraps to itself, which is the
  // correct unsigned magnitude 2^(WIDTH-1).
  assign abs_a = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign abs_b = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

  // Shift-add: upper half plus multiplicand, carry kept for the shift.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};

  // Restoring divide: acc holds {remainder, dividend bits/quotient bits};
  // shift the next dividend bit into the partial remainder and trial-subtract.
  assign rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign rem_sub = rem_sh - {1'b0, mag_b};
  assign rem_ge  = (rem_sh >= {1'b0, mag_b});

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rmd_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // ------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      mag_a <= '0;
      mag_b <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      acc   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
          if (start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
          end
        end
        S_PREP: begin
          count <= '0;
          mag_a <= abs_a;
          mag_b <= abs_b;
          neg_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_r <= is_signed & a_q[WIDTH-1];
          // Multiply shifts the multiplier out of the low half; divide
          // shifts the dividend out of the low half.
          acc   <= is_div ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
        end
        S_ITER: begin
          count <= count + CW'(1);
          if (is_div) begin
            if (rem_ge) acc <= {rem_sub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else        acc <= {rem_sh[WIDTH-1:0],  acc[WIDTH-2:0], 1'b0};
          end else begin
            if (acc[0]) acc <= {mul_sum, acc[WIDTH-1:1]};
            else        acc <= {1'b0, acc[2*WIDTH-1:1]};
          end
        end
        S_FIX: begin
          if (!is_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (b_q == '0) begin
            hi <= a_q;
            lo <= '1;
          end else begin
            hi <= rmd_fix;
            lo <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// ---------------------------------------------------------------------------
// tb_hilo_mdu
//   Self-checking bench for hilo_mdu (WIDTH=32). Reference results come from
//   64-bit integer arithmetic; HI/LO are tracked as plain model variables.
//   Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_hilo_mdu;

  localparam int W = 32;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a, b;
  logic          mthi, mtlo;
  logic [W-1:0]  wdata;
  logic          busy, done;
  logic [W-1:0]  hi, lo;
  logic [1:0]    fsm_state;

  hilo_mdu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .fsm_state (fsm_state)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_hi, exp_lo;
  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model: returns {hi, lo}
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [63:0] sx, sy, p, q, r;
    logic [63:0] ux, uy, res;
    sx = 64'(signed'(x));
    sy = 64'(signed'(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    res = '0;
    case (o)
      2'b00: begin p = sx * sy; res = p; end
      2'b01: res = ux * uy;
      2'b10: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else begin
          q = ux / uy;
          r = ux % uy;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  task automatic idle_inputs();
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
  endtask

  // Called positioned at a falling edge (cycle 0); returns at the falling
  // edge of cycle 35 after checking results.
  task automatic run_op(input logic [1:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        input bit disturb, input bit mv_hi, input bit mv_lo, input logic [W-1:0] wd);
    logic [63:0] r;
    r = ref_result(op_i, a_i, b_i);
    exp_q.push_back(r[63:32]);
    exp_q.push_back(r[31:0]);
    start = 1'b1; op = op_i; a = a_i; b = b_i;
    mthi = mv_hi; mtlo = mv_lo; wdata = wd;
    if (mv_hi) exp_hi = wd;
    if (mv_lo) exp_lo = wd;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      idle_inputs();
      op = 2'($urandom); a = $urandom; b = $urandom; wdata = $urandom;
      if (disturb && c == 10) begin
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234;
      end
      check("busy_in_flight", {31'b0, busy}, 32'd1);
      check("done_in_flight", {31'b0, done}, 32'd0);
      check("hi_hold", hi, exp_hi);
      check("lo_hold", lo, exp_lo);
    end
    @(negedge clk);
    idle_inputs();
    exp_hi = exp_q.pop_front();
    exp_lo = exp_q.pop_front();
    check("busy_end", {31'b0, busy}, 32'd0);
    check("done_pulse", {31'b0, done}, 32'd1);
    check("hi_result", hi, exp_hi);
    check("lo_result", lo, exp_lo);
  endtask

  task automatic do_move(input bit mv_hi, input bit mv_lo, input logic [W-1:0] wd);
    mthi = mv_hi; mtlo = mv_lo; wdata = wd; start = 1'b0;
    @(negedge clk);
    idle_inputs();
    if (mv_hi) exp_hi = wd;
    if (mv_lo) exp_lo = wd;
    check("move_hi", hi, exp_hi);
    check("move_lo", lo, exp_lo);
    check("move_no_done", {31'b0, done}, 32'd0);
    check("move_no_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    exp_hi = '0; exp_lo = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    @(negedge clk);

    // directed operations, issued back-to-back
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, '0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5,          0, 0, 0, '0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000,  0, 0, 0, '0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2,          0, 0, 0, '0);
    run_op(2'b11, 32'd7,         32'd2,          0, 0, 0, '0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  0, 0, 0, '0);
    run_op(2'b11, 32'd100,       32'd0,          0, 0, 0, '0);
    run_op(2'b10, 32'hFFFF_FF00, 32'd0,          0, 0, 0, '0);
    run_op(2'b10, 32'd7,         32'hFFFF_FFFE,  0, 0, 0, '0);

    // start and moves during an operation are dropped
    run_op(2'b01, 32'd6, 32'd7, 1, 0, 0, '0);
    @(negedge clk);
    check("single_done", {31'b0, done}, 32'd0);

    // moves while idle
    do_move(1, 0, 32'h0000_ABCD);
    do_move(0, 1, 32'h1357_9BDF);
    do_move(1, 1, 32'hDEAD_BEEF);

    // move together with start: applied, then overwritten by the result
    run_op(2'b11, 32'd1000, 32'd33, 0, 1, 1, 32'h5555_AAAA);

    // reset in the middle of a DIV
    start = 1'b1; op = 2'b10; a = 32'hFFFF_FFF9; b = 32'd2;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      idle_inputs();
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    for (int c = 12; c <= 36; c++) begin
      @(negedge clk);
      check("abort_no_done", {31'b0, done}, 32'd0);
      check("abort_idle", {31'b0, busy}, 32'd0);
    end
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, '0);

    // randomized back-to-back operations
    for (int i = 0; i < 40; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(ro, ra, rb, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)), $urandom);
    end
    @(negedge clk);
    check("final_done_low", {31'b0, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
